axi_mem_if_hp_port_ctrl: RTL and testbench

Upstream feeder for the HP port of the hybrid dual-port AXI memory interface. It accepts TCDM-style req/gnt/r_valid transactions from a core or DMA and buffers them in a small request FIFO. It drives the HP_cen/wen/addr/wdata/be lines and returns read data from HP Q.
Because the HP port has absolute priority over the LP AXI path, the block enforces a fairness yield: after MAX_BURST consecutive HP accesses, while the LP side has pending work, it leaves one idle cycle.

---
 rtl/axi_mem_if_hp_port_ctrl_pkg.sv | 26 ++
 rtl/axi_mem_if_hp_port_ctrl_if.sv | 41 ++++
 rtl/axi_mem_if_hp_port_ctrl_fifo.sv | 55 +++++
 rtl/axi_mem_if_hp_port_ctrl.sv | 123 ++++++++++++
 tb/tb_axi_mem_if_hp_port_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mem_if_hp_port_ctrl_pkg.sv
// Shared types and helpers for the HP port feeder.
// Request record, yield FSM states and address offset helper.
package axi_mem_if_hp_pkg;

    localparam int HP_DATA_WIDTH     = 64;
    localparam int HP_BE_WIDTH       = HP_DATA_WIDTH / 8;
    localparam int HP_MEM_ADDR_WIDTH = 13;

    typedef struct packed {
        logic                         wen;
        logic [HP_MEM_ADDR_WIDTH-1:0] addr;
        logic [HP_DATA_WIDTH-1:0]     wdata;
        logic [HP_BE_WIDTH-1:0]       be;
    } hp_req_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_YIELD = 1'b1
    } hp_state_e;

    // Byte offset bits dropped when turning a byte address into a word address.
    function automatic int offset_bit(input int data_width);
        return $clog2(data_width) - 3;
    endfunction

endpackage

// File: rtl/axi_mem_if_hp_port_ctrl_if.sv
// TCDM request side, LP status and HP memory lines of the HP feeder.
// master = core/DMA plus memory, slave = the feeder.
interface axi_mem_if_hp_port_ctrl_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 13
);

    logic                      data_req_i;
    logic [ADDR_WIDTH-1:0]     data_add_i;
    logic                      data_wen_i;
    logic [DATA_WIDTH-1:0]     data_wdata_i;
    logic [BE_WIDTH-1:0]       data_be_i;
    logic                      data_gnt_o;
    logic                      data_r_valid_o;
    logic [DATA_WIDTH-1:0]     data_r_rdata_o;
    logic                      lp_pending_i;
    logic                      HP_cen_o;
    logic                      HP_wen_o;
    logic [MEM_ADDR_WIDTH-1:0] HP_addr_o;
    logic [DATA_WIDTH-1:0]     HP_wdata_o;
    logic [BE_WIDTH-1:0]       HP_be_o;
    logic [DATA_WIDTH-1:0]     HP_Q_i;
    logic                      busy_o;

    modport master (
        output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
        output lp_pending_i, HP_Q_i,
        input  data_gnt_o, data_r_valid_o, data_r_rdata_o,
        input  HP_cen_o, HP_wen_o, HP_addr_o, HP_wdata_o, HP_be_o, busy_o
    );

    modport slave (
        input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
        input  lp_pending_i, HP_Q_i,
        output data_gnt_o, data_r_valid_o, data_r_rdata_o,
        output HP_cen_o, HP_wen_o, HP_addr_o, HP_wdata_o, HP_be_o, busy_o
    );

endinterface

// File: rtl/axi_mem_if_hp_port_ctrl_fifo.sv
// Request FIFO for the HP feeder: wrap-bit pointers, head is
// combinational; pushes while full and pops while empty are ignored.
module hp_req_fifo
    import axi_mem_if_hp_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = hp_req_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  T     din,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    T                   mem [DEPTH];
    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                     (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
    assign head    = mem[rd_ptr[PTR_WIDTH-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (PTR_WIDTH+1)'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + (PTR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[PTR_WIDTH-1:0]] <= din;
        end
    end

endmodule

// File: rtl/axi_mem_if_hp_port_ctrl.sv
// HP port feeder: buffers TCDM requests, drives the HP memory lines and
// inserts one idle cycle after a long burst while LP work is pending.
module axi_mem_if_hp_port_ctrl
    import axi_mem_if_hp_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_BURST      = 8
) (
    input logic ACLK,
    input logic ARESETn,
    axi_mem_if_hp_port_ctrl_if.slave bus
);

    localparam int OFFSET_BIT = offset_bit(DATA_WIDTH);
    localparam int CNT_WIDTH  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] BURST_MAX = CNT_WIDTH'(MAX_BURST);
    localparam logic [CNT_WIDTH:0]   BURST_CMP = (CNT_WIDTH+1)'(MAX_BURST);

    typedef struct packed {
        logic                      wen;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     wdata;
        logic [BE_WIDTH-1:0]       be;
    } req_t;

    req_t                 push_req;
    req_t                 head;
    logic                 push;
    logic                 full;
    logic                 empty;
    logic                 issue;
    logic                 yield_set;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH:0]   cnt_inc;
    hp_state_e            state;
    hp_state_e            state_next;
    logic                 unused_addr;

    assign push          = bus.data_req_i && !full;
    assign push_req.wen   = bus.data_wen_i;
    assign push_req.addr  = bus.data_add_i[OFFSET_BIT +: MEM_ADDR_WIDTH];
    assign push_req.wdata = bus.data_wdata_i;
    assign push_req.be    = bus.data_be_i;
    assign bus.data_gnt_o = !full;
    assign unused_addr    = ^bus.data_add_i;

    hp_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .push  (push),
        .pop   (issue),
        .din   (push_req),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign issue     = !empty && (state == ST_RUN);
    assign cnt_inc   = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
    assign yield_set = issue && bus.lp_pending_i &&
                       (MAX_BURST != 0) && (cnt_inc == BURST_CMP);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            state <= ST_RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_RUN:   if (yield_set) state_next = ST_YIELD;
            ST_YIELD: state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // Any idle cycle, including the yield cycle itself, restarts the burst.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            cnt <= '0;
        else if (!issue)
            cnt <= '0;
        else if (cnt != BURST_MAX)
            cnt <= cnt_inc[CNT_WIDTH-1:0];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            r_valid <= 1'b0;
        else
            r_valid <= issue;
    end

    always_comb begin
        bus.HP_cen_o   = 1'b1;
        bus.HP_wen_o   = 1'b1;
        bus.HP_addr_o  = '0;
        bus.HP_wdata_o = '0;
        bus.HP_be_o    = '0;
        if (issue) begin
            bus.HP_cen_o   = 1'b0;
            bus.HP_wen_o   = head.wen;
            bus.HP_addr_o  = head.addr;
            bus.HP_wdata_o = head.wdata;
            bus.HP_be_o    = head.be;
        end
    end

    assign bus.data_r_valid_o = r_valid;
    assign bus.data_r_rdata_o = bus.HP_Q_i;
    assign bus.busy_o         = !empty || r_valid;

endmodule

// File: tb/tb_axi_mem_if_hp_port_ctrl.sv
// Bench for the HP feeder: instance 0 (depth 4, burst 4), instance 1
// (depth 2, burst 1), each shadowed by a queue-based reference model.
module tb_axi_mem_if_hp_port_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic        req   [2];
    logic [31:0] add   [2];
    logic        wen   [2];
    logic [63:0] wd    [2];
    logic [7:0]  be    [2];
    logic        lp    [2];
    logic [63:0] q_in  [2];

    logic        gnt   [2];
    logic        rv    [2];
    logic [63:0] rdata [2];
    logic        cen   [2];
    logic        hwen  [2];
    logic [12:0] haddr [2];
    logic [63:0] hwd   [2];
    logic [7:0]  hbe   [2];
    logic        busy  [2];

    typedef struct {
        logic        wen;
        logic [12:0] addr;
        logic [63:0] wd;
        logic [7:0]  be;
    } mreq_t;

    int accepted [2];

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int DEP = (k == 0) ? 4 : 2;
        localparam int MB  = (k == 0) ? 4 : 1;

        axi_mem_if_hp_port_ctrl_if bus ();

        assign bus.data_req_i   = req[k];
        assign bus.data_add_i   = add[k];
        assign bus.data_wen_i   = wen[k];
        assign bus.data_wdata_i = wd[k];
        assign bus.data_be_i    = be[k];
        assign bus.lp_pending_i = lp[k];
        assign bus.HP_Q_i       = q_in[k];
        assign gnt[k]   = bus.data_gnt_o;
        assign rv[k]    = bus.data_r_valid_o;
        assign rdata[k] = bus.data_r_rdata_o;
        assign cen[k]   = bus.HP_cen_o;
        assign hwen[k]  = bus.HP_wen_o;
        assign haddr[k] = bus.HP_addr_o;
        assign hwd[k]   = bus.HP_wdata_o;
        assign hbe[k]   = bus.HP_be_o;
        assign busy[k]  = bus.busy_o;

        axi_mem_if_hp_port_ctrl #(
            .FIFO_DEPTH (DEP),
            .MAX_BURST  (MB)
        ) dut (
            .ACLK    (clk),
            .ARESETn (rst_n),
            .bus     (bus)
        );

        // Reference: pending requests in order, length of current burst,
        // and whether the next cycle is a forced idle one.
        mreq_t q[$];
        int    burst = 0;
        bit    yld = 1'b0;
        bit    resp = 1'b0;

        always @(posedge clk or negedge rst_n) begin
            bit    iss;
            bit    psh;
            mreq_t r;
            if (!rst_n) begin
                q.delete();
                burst = 0;
                yld = 1'b0;
                resp = 1'b0;
            end else begin
                iss = (q.size() != 0) && !yld;
                psh = req[k] && (q.size() < DEP);
                if (iss)
                    void'(q.pop_front());
                if (psh) begin
                    r.wen  = wen[k];
                    r.addr = add[k][15:3];
                    r.wd   = wd[k];
                    r.be   = be[k];
                    q.push_back(r);
                    accepted[k]++;
                end
                if (yld) begin
                    yld = 1'b0;
                    burst = 0;
                end else if (iss) begin
                    if (burst + 1 == MB && lp[k])
                        yld = 1'b1;
                    if (burst < MB)
                        burst++;
                end else begin
                    burst = 0;
                end
                resp = iss;
            end
        end

        always @(negedge clk) begin
            logic [89:0] ev;
            logic [89:0] av;
            bit          iss;
            if (mon_en) begin
                iss = (q.size() != 0) && !yld;
                if (iss)
                    ev = {1'b0, q[0].wen, q[0].addr, q[0].wd, q[0].be,
                          (q.size() < DEP), resp, 1'b1};
                else
                    ev = {1'b1, 1'b1, 13'd0, 64'd0, 8'd0,
                          (q.size() < DEP), resp, (q.size() != 0) || resp};
                av = {cen[k], hwen[k], haddr[k], hwd[k], hbe[k],
                      gnt[k], rv[k], busy[k]};
                checks++;
                if (av !== ev) begin
                    errors++;
                    $display("FAIL model%0d t=%0t act %h exp %h", k, $time, av, ev);
                end
                checks++;
                if (rdata[k] !== q_in[k]) begin
                    errors++;
                    $display("FAIL rdata%0d act %h exp %h", k, rdata[k], q_in[k]);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++)
                req[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({cen[k], hwen[k], haddr[k], hbe[k], hwd[k], gnt[k], rv[k], busy[k]} !==
                {1'b1, 1'b1, 13'd0, 8'd0, 64'd0, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_state%0d cen %b gnt %b rv %b busy %b exp 1 1 0 0",
                         k, cen[k], gnt[k], rv[k], busy[k]);
            end
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cen[0] !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset cen %b exp 1", cen[0]);
        end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        #1;
        req[0] = 1'b1; add[0] = 32'h40; wen[0] = 1'b1;
        q_in[0] = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        checks++;
        if ({cen[0], hwen[0], haddr[0]} !== {1'b0, 1'b1, 13'd8}) begin
            errors++;
            $display("FAIL read_issue cen %b wen %b addr %0d exp 0 1 8", cen[0], hwen[0], haddr[0]);
        end
        #1 req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({rv[0], cen[0], rdata[0]} !== {1'b1, 1'b1, 64'hDEADBEEF_CAFEF00D}) begin
            errors++;
            $display("FAIL read_resp rv %b cen %b data %h exp 1 1 deadbeefcafef00d",
                     rv[0], cen[0], rdata[0]);
        end
        @(negedge clk);
        checks++;
        if (rv[0] !== 1'b0) begin
            errors++;
            $display("FAIL read_resp_once rv %b exp 0", rv[0]);
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        #1;
        req[0] = 1'b1; add[0] = 32'h18; wen[0] = 1'b0;
        wd[0] = 64'h1122334455667788; be[0] = 8'h0F;
        @(negedge clk);
        checks++;
        if ({cen[0], hwen[0], haddr[0], hbe[0], hwd[0]} !==
            {1'b0, 1'b0, 13'd3, 8'h0F, 64'h1122334455667788}) begin
            errors++;
            $display("FAIL write_issue cen %b wen %b addr %0d be %h data %h exp 0 0 3 0f 1122334455667788",
                     cen[0], hwen[0], haddr[0], hbe[0], hwd[0]);
        end
        #1 req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (rv[0] !== 1'b1) begin
            errors++;
            $display("FAIL write_resp rv %b exp 1", rv[0]);
        end
        @(negedge clk);
        checks++;
        if (rv[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_resp_once rv %b exp 0", rv[0]);
        end
    endtask

    task automatic test_burst_yield();
        logic [11:0] pat;
        int nrv = 0;
        int nissue = 0;
        lp[0] = 1'b1;
        @(negedge clk);
        #1;
        req[0] = 1'b1; add[0] = 32'h0; wen[0] = 1'($urandom); wd[0] = {$urandom, $urandom};
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i < 12)
                pat[i] = cen[0];
            if (!cen[0]) begin
                checks++;
                if (haddr[0] !== 13'(nissue)) begin
                    errors++;
                    $display("FAIL burst_order addr %0d exp %0d", haddr[0], nissue);
                end
                nissue++;
            end
            if (rv[0])
                nrv++;
            #1;
            if (i < 9) begin
                add[0] = 32'((i + 1) * 8);
                wen[0] = 1'($urandom);
                wd[0] = {$urandom, $urandom};
            end else begin
                req[0] = 1'b0;
            end
        end
        checks++;
        if (pat !== 12'h210) begin
            errors++;
            $display("FAIL burst_pattern act %b exp %b", pat, 12'h210);
        end
        checks++;
        if (nrv !== 10) begin
            errors++;
            $display("FAIL burst_rvalid act %0d exp 10", nrv);
        end
        lp[0] = 1'b0;
        idle(3);
    endtask

    task automatic test_lp_idle();
        int run = 0;
        int maxrun = 0;
        lp[0] = 1'b0;
        @(negedge clk);
        #1;
        req[0] = 1'b1; add[0] = 32'h100; wen[0] = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (!cen[0]) begin
                run++;
                if (run > maxrun)
                    maxrun = run;
            end else begin
                run = 0;
            end
            #1;
            if (i < 19)
                add[0] = 32'h100 + 32'((i + 1) * 8);
            else
                req[0] = 1'b0;
        end
        checks++;
        if (maxrun !== 20) begin
            errors++;
            $display("FAIL no_yield_run act %0d exp 20", maxrun);
        end
        idle(2);
    endtask

    task automatic test_fifo_full();
        int  n = 0;
        int  nlow = 0;
        int  next_iss = 0;
        int  nrv = 0;
        int  doubles = 0;
        bit  prev_cen = 1'b1;
        bit  gsamp;
        lp[1] = 1'b1;
        for (int c = 0; c < 42; c++) begin
            @(negedge clk);
            gsamp = gnt[1];
            if (!cen[1]) begin
                checks++;
                if (haddr[1] !== 13'(next_iss)) begin
                    errors++;
                    $display("FAIL full_order addr %0d exp %0d", haddr[1], next_iss);
                end
                next_iss++;
                if (!prev_cen)
                    doubles++;
            end
            prev_cen = cen[1];
            if (rv[1])
                nrv++;
            #1;
            if (c < 30) begin
                if (!gsamp)
                    nlow++;
                req[1] = 1'b1;
                add[1] = 32'(n * 8);
                wen[1] = 1'($urandom);
                wd[1] = {$urandom, $urandom};
                be[1] = 8'($urandom);
                if (gsamp)
                    n++;
            end else begin
                req[1] = 1'b0;
            end
        end
        checks++;
        if (nlow == 0) begin
            errors++;
            $display("FAIL full_gnt_low act %0d exp >0", nlow);
        end
        checks++;
        if (doubles !== 0) begin
            errors++;
            $display("FAIL full_alternate act %0d exp 0", doubles);
        end
        checks++;
        if (next_iss !== n || nrv !== n) begin
            errors++;
            $display("FAIL full_count issued %0d resp %0d exp %0d", next_iss, nrv, n);
        end
        lp[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        lp[0] = 1'b1;
        @(negedge clk);
        #1;
        req[0] = 1'b1; add[0] = 32'h200; wen[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({rv[0], busy[0], cen[0]} !== 3'b111) begin
            errors++;
            $display("FAIL pre_reset rv %b busy %b cen %b exp 1 1 1", rv[0], busy[0], cen[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({cen[k], rv[k], gnt[k], busy[k]} !== 4'b1010) begin
                errors++;
                $display("FAIL mid_reset%0d cen %b rv %b gnt %b busy %b exp 1 0 1 0",
                         k, cen[k], rv[k], gnt[k], busy[k]);
            end
        end
        req[0] = 1'b0;
        lp[0] = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({cen[0], busy[0]} !== 2'b10) begin
                errors++;
                $display("FAIL post_reset cen %b busy %b exp 1 0", cen[0], busy[0]);
            end
        end
    endtask

    task automatic test_random();
        int base [2];
        int nrv  [2];
        for (int k = 0; k < 2; k++) begin
            base[k] = accepted[k];
            nrv[k] = 0;
        end
        for (int c = 0; c < 415; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                if (rv[k])
                    nrv[k]++;
            #1;
            for (int k = 0; k < 2; k++) begin
                req[k] = (c < 400) && ($urandom_range(0, 3) != 0);
                add[k] = $urandom;
                wen[k] = 1'($urandom);
                wd[k] = {$urandom, $urandom};
                be[k] = 8'($urandom);
                lp[k] = ($urandom_range(0, 2) != 0);
                q_in[k] = {$urandom, $urandom};
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (nrv[k] !== accepted[k] - base[k]) begin
                errors++;
                $display("FAIL random_resp%0d act %0d exp %0d", k, nrv[k], accepted[k] - base[k]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; add[k] = '0; wen[k] = 1'b1; wd[k] = '0;
            be[k] = '0; lp[k] = 1'b0; q_in[k] = '0; accepted[k] = 0;
        end
        mon_en = 1'b1;
        test_reset();
        test_single_read();
        test_write();
        test_burst_yield();
        test_lp_idle();
        test_fifo_full();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
